// File: rtl/lock_reset_sequencer.sv
// Turns the clock manager's asynchronous lock flag into a clean synchronous reset
// for derived-clock logic, restarting the clock manager on lock timeout or lock loss.
module lock_reset_sequencer #(
    parameter logic [31:0] StableCycles   = 32'd1024,
    parameter logic [31:0] TimeoutCycles  = 32'h000FFFFF,
    parameter logic [31:0] DcmResetCycles = 32'd8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       dcm_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [7:0] timeout_count
);

    typedef enum logic [1:0] {
        ST_RESET_DCM,
        ST_WAIT_LOCK,
        ST_STABILIZE,
        ST_RUN
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_sync;
    logic        r_dcm_reset;
    logic        r_sys_reset;
    logic        r_ready;
    logic [7:0]  r_relock_count;
    logic [7:0]  r_timeout_count;
    logic        w_locked_s;

    assign w_locked_s = r_sync[1];

    // Two-flop synchronizer; locked is asynchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], locked};
        end
    end

    // Outputs are registered alongside the state so they always equal the
    // decode of the state that is currently held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_RESET_DCM;
            r_cnt           <= 32'd0;
            r_dcm_reset     <= 1'b1;
            r_sys_reset     <= 1'b1;
            r_ready         <= 1'b0;
            r_relock_count  <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            case (r_state)
                ST_RESET_DCM: begin
                    if (r_cnt == DcmResetCycles - 32'd1) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_cnt       <= 32'd0;
                        r_dcm_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle wins; no timeout is counted.
                    if (w_locked_s) begin
                        r_state <= ST_STABILIZE;
                        r_cnt   <= 32'd0;
                    end else if (r_cnt == TimeoutCycles - 32'd1) begin
                        r_state     <= ST_RESET_DCM;
                        r_cnt       <= 32'd0;
                        r_dcm_reset <= 1'b1;
                        if (r_timeout_count != 8'hFF) begin
                            r_timeout_count <= r_timeout_count + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                ST_STABILIZE: begin
                    if (!w_locked_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= 32'd0;
                    end else if (r_cnt == StableCycles - 32'd1) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= 32'd0;
                        r_sys_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end

                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state     <= ST_RESET_DCM;
                        r_cnt       <= 32'd0;
                        r_dcm_reset <= 1'b1;
                        r_sys_reset <= 1'b1;
                        r_ready     <= 1'b0;
                        if (r_relock_count != 8'hFF) begin
                            r_relock_count <= r_relock_count + 8'd1;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_RESET_DCM;
                    r_cnt       <= 32'd0;
                    r_dcm_reset <= 1'b1;
                    r_sys_reset <= 1'b1;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    assign dcm_reset     = r_dcm_reset;
    assign sys_reset     = r_sys_reset;
    assign ready         = r_ready;
    assign relock_count  = r_relock_count;
    assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Randomized and directed bench for lock_reset_sequencer, checked every cycle
// against a countdown-based behavioural model of the lock sequencing rules.
module tb_lock_reset_sequencer;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 16;
    localparam int DCMRST  = 3;

    localparam int PH_DCM  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       dcm_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic [7:0] timeout_count;

    int checkCount = 0;
    int errorCount = 0;

    // Model: current phase, cycles left in its budget, delayed lock view, counts.
    int mPhase;
    int mLeft;
    bit mDelay0, mDelay1;
    int mRelock, mTimeout;

    always #5 clock = ~clock;

    lock_reset_sequencer #(
        .StableCycles   (32'(STABLE)),
        .TimeoutCycles  (32'(TIMEOUT)),
        .DcmResetCycles (32'(DCMRST))
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .locked        (locked),
        .dcm_reset     (dcm_reset),
        .sys_reset     (sys_reset),
        .ready         (ready),
        .relock_count  (relock_count),
        .timeout_count (timeout_count)
    );

    function automatic int satInc(int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function void modelEnter(int ph);
        mPhase = ph;
        case (ph)
            PH_DCM:  mLeft = DCMRST;
            PH_WAIT: mLeft = TIMEOUT;
            PH_STAB: mLeft = STABLE;
            default: mLeft = 0;
        endcase
    endfunction

    function void modelStep(bit rst, bit lk);
        bit seen;
        if (rst) begin
            modelEnter(PH_DCM);
            mDelay0  = 1'b0;
            mDelay1  = 1'b0;
            mRelock  = 0;
            mTimeout = 0;
        end else begin
            seen    = mDelay1;
            mDelay1 = mDelay0;
            mDelay0 = lk;
            case (mPhase)
                PH_DCM: begin
                    if (mLeft == 1) modelEnter(PH_WAIT);
                    else mLeft--;
                end
                PH_WAIT: begin
                    if (seen) modelEnter(PH_STAB);
                    else if (mLeft == 1) begin
                        mTimeout = satInc(mTimeout);
                        modelEnter(PH_DCM);
                    end else mLeft--;
                end
                PH_STAB: begin
                    if (!seen) modelEnter(PH_WAIT);
                    else if (mLeft == 1) modelEnter(PH_RUN);
                    else mLeft--;
                end
                default: begin
                    if (!seen) begin
                        mRelock = satInc(mRelock);
                        modelEnter(PH_DCM);
                    end
                end
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("dcm_reset", 32'(dcm_reset), 32'(mPhase == PH_DCM));
        checkOutput("sys_reset", 32'(sys_reset), 32'(mPhase != PH_RUN));
        checkOutput("ready", 32'(ready), 32'(mPhase == PH_RUN));
        checkOutput("relock_count", 32'(relock_count), 32'(mRelock));
        checkOutput("timeout_count", 32'(timeout_count), 32'(mTimeout));
    endtask

    // Drive inputs at the falling edge, advance the model on the rising edge,
    // and compare at the next falling edge.
    task automatic applyStimulus(input bit rst, input bit lk);
        reset  = rst;
        locked = lk;
        @(posedge clock);
        modelStep(rst, lk);
        @(negedge clock);
        compareAll();
    endtask

    task automatic holdUntilReady(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checkOutput(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int savedRelock, savedTimeout;
        reset  = 1'b1;
        locked = 1'b0;
        @(negedge clock);

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_dcm_reset", 32'(dcm_reset), 32'd1);

        // dcm_reset pulse length after release, including the cycle after the reset edge
        n = 0;
        while (dcm_reset === 1'b1 && n < 20) begin
            n++;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("dcm_pulse_len", 32'(n), 32'(DCMRST));

        // Lock acquisition: sys_reset falls StableCycles+2 edges after the sampling edge
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end while (sys_reset !== 1'b0 && n < 50);
        checkOutput("lock_latency", 32'(n - 1), 32'(STABLE + 2));
        checkOutput("lock_ready", 32'(ready), 32'd1);

        // Lock loss in RUN for 5 cycles: sys_reset set on the 3rd edge
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end while (sys_reset !== 1'b1 && n < 20);
        checkOutput("loss_latency", 32'(n), 32'd3);
        for (int i = n; i < 5; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("relock_after_loss", 32'(relock_count), 32'd1);
        holdUntilReady("relock_ready");

        // Single-cycle lock drop seen while STABILIZE is at cnt=2
        n = 0;
        while (!(mPhase == PH_WAIT && mLeft == TIMEOUT) && n < 50) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        n = 0;
        while (!(mPhase == PH_STAB && mLeft == STABLE) && n < 50) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        savedRelock  = mRelock;
        savedTimeout = mTimeout;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stab_glitch_back", 32'(sys_reset), 32'd1);
        checkOutput("stab_glitch_relock", 32'(relock_count), 32'(savedRelock));
        checkOutput("stab_glitch_timeout", 32'(timeout_count), 32'(savedTimeout));
        holdUntilReady("stab_restart_ready");

        // Build relock_count up to 5, then reset mid-RUN
        n = 0;
        while (mRelock < 5 && n < 10) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
            holdUntilReady("relock_build_ready");
            n++;
        end
        checkOutput("relock_five", 32'(relock_count), 32'd5);
        applyStimulus(1'b1, 1'b1);
        checkOutput("run_reset_sys", 32'(sys_reset), 32'd1);
        checkOutput("run_reset_relock", 32'(relock_count), 32'd0);

        // Lock never arrives: timeouts every DCMRST+TIMEOUT cycles until saturation
        for (int i = 0; i < DCMRST + TIMEOUT; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("first_timeout", 32'(timeout_count), 32'd1);
        checkOutput("first_timeout_pulse", 32'(dcm_reset), 32'd1);
        for (int i = 0; i < 260 * (DCMRST + TIMEOUT); i++) applyStimulus(1'b0, 1'b0);
        checkOutput("timeout_saturated", 32'(timeout_count), 32'd255);

        // Randomized runs of lock/unlock with occasional resets
        for (int run = 0; run < 300; run++) begin
            bit lk;
            bit rst;
            int len;
            lk  = ($urandom_range(0, 2) != 0);
            len = $urandom_range(1, 25);
            rst = ($urandom_range(0, 60) == 0);
            if (rst) applyStimulus(1'b1, lk);
            for (int i = 0; i < len; i++) applyStimulus(1'b0, lk);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
